// File: rtl/score_bcd_display_pkg.sv
// Shared types and the 7-segment glyph table for the banner score renderer.
// Segment vector bit order is {g,f,e,d,c,b,a}.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_A = 7'b0000001;
    localparam logic [6:0] SEG_B = 7'b0000010;
    localparam logic [6:0] SEG_C = 7'b0000100;
    localparam logic [6:0] SEG_D = 7'b0001000;
    localparam logic [6:0] SEG_E = 7'b0010000;
    localparam logic [6:0] SEG_F = 7'b0100000;
    localparam logic [6:0] SEG_G = 7'b1000000;

    // Codes 10-15 map to no segments, so 4'hF doubles as the "blank cell" code.
    function automatic logic [6:0] digit_segs(input bcd_digit_t d);
        case (d)
            4'd0:    return SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            4'd1:    return SEG_B | SEG_C;
            4'd2:    return SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
            4'd3:    return SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
            4'd4:    return SEG_B | SEG_C | SEG_F | SEG_G;
            4'd5:    return SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
            4'd6:    return SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'd7:    return SEG_A | SEG_B | SEG_C;
            4'd8:    return SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'd9:    return SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
            default: return 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/score_bcd_display_glyph.sv
// One 7-segment glyph cell: decides whether a cell-local pixel is lit for a digit.
// Segment bands are derived from the cell size (thirds across, sevenths down).
import score_pkg::*;

module digit_glyph #(
    parameter int DIGIT_WIDTH  = 12,
    parameter int DIGIT_HEIGHT = 28
) (
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  bcd_digit_t  i_digit,
    output logic        o_lit
);
    localparam logic [9:0] TX  = 10'(DIGIT_WIDTH / 3);
    localparam logic [9:0] RX  = 10'(DIGIT_WIDTH - DIGIT_WIDTH / 3);
    localparam logic [9:0] HS1 = 10'(DIGIT_HEIGHT / 7);
    localparam logic [9:0] HS3 = 10'(3 * (DIGIT_HEIGHT / 7));
    localparam logic [9:0] HS4 = 10'(4 * (DIGIT_HEIGHT / 7));
    localparam logic [9:0] HS6 = 10'(6 * (DIGIT_HEIGHT / 7));

    logic [6:0] w_on;

    assign w_on[0] = (i_y < HS1);
    assign w_on[1] = (i_x >= RX) && (i_y < HS4);
    assign w_on[2] = (i_x >= RX) && (i_y >= HS3);
    assign w_on[3] = (i_y >= HS6);
    assign w_on[4] = (i_x < TX) && (i_y >= HS3);
    assign w_on[5] = (i_x < TX) && (i_y < HS4);
    assign w_on[6] = (i_y >= HS3) && (i_y < HS4);

    assign o_lit = |(digit_segs(i_digit) & w_on);

endmodule

// File: rtl/score_bcd_display.sv
// Live/high score keeper in BCD plus 7-segment banner renderer.
// Registered pixel output: one cycle of latency from i_hpos/i_vpos.
import score_pkg::*;

module score_bcd_display #(
    parameter int          NUM_DIGITS    = 3,
    parameter int          DIGIT_WIDTH   = 12,
    parameter int          DIGIT_HEIGHT  = 28,
    parameter int          DIGIT_GAP     = 4,
    parameter int          SCORE_X       = 590,
    parameter int          HIGH_X        = 8,
    parameter int          DIGIT_Y       = 2,
    parameter int          BANNER_HEIGHT = 32,
    parameter logic [2:0]  SCORE_COLOR   = 3'b100,
    parameter logic [2:0]  HIGH_COLOR    = 3'b110,
    parameter logic [2:0]  BANNER_COLOR  = 3'b000,
    parameter int          BLINK_FRAMES  = 16,
    parameter int          BLANK_LEADING = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [9:0]                i_hpos,
    input  logic [9:0]                i_vpos,
    input  logic                      i_frame_tick,
    input  logic                      i_score_inc,
    input  logic                      i_score_clr,
    output logic [4*NUM_DIGITS-1:0]   o_score_bcd,
    output logic [4*NUM_DIGITS-1:0]   o_high_bcd,
    output logic                      o_new_high,
    output logic [2:0]                o_score_rgb
);
    localparam int SW    = 4 * NUM_DIGITS;
    localparam int PITCH = DIGIT_WIDTH + DIGIT_GAP;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SW-1:0]   r_score;
    logic [SW-1:0]   r_high;
    logic            r_new_high;
    logic [FC_W-1:0] r_frame_cnt;
    logic            r_blink;
    logic [2:0]      r_rgb;

    logic [SW-1:0]   w_score_inc;
    logic [SW-1:0]   w_score_next;
    bcd_digit_t      w_score_disp [NUM_DIGITS];
    bcd_digit_t      w_high_disp  [NUM_DIGITS];
    logic            w_live_hit, w_high_hit, w_in_row;
    logic            w_live_lit, w_high_lit;
    bcd_digit_t      w_live_digit, w_high_digit;
    logic [9:0]      w_live_lx, w_high_lx, w_ly;
    logic [2:0]      w_rgb_next;

    // Ripple BCD increment; holds at all-9s instead of wrapping to zero.
    always_comb begin : inc_logic
        logic carry;
        logic sat;
        w_score_inc = r_score;
        carry = 1'b1;
        sat   = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (r_score[4*j +: 4] != 4'd9) sat = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (carry && !sat) begin
                if (r_score[4*j +: 4] == 4'd9) begin
                    w_score_inc[4*j +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*j +: 4] = r_score[4*j +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    assign w_score_next = i_score_clr ? '0 : (i_score_inc ? w_score_inc : r_score);

    // Valid BCD orders the same as plain binary, so a vector compare is an MSD-first compare.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_score    <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
        end else begin
            r_score    <= w_score_next;
            if (i_score_clr && (r_score > r_high))
                r_high <= r_score;
            r_new_high <= !i_score_clr && (w_score_next > r_high);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (i_frame_tick) begin
            if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Leading zeros become code 4'hF (blank); the ones digit always shows.
    always_comb begin : blanking
        logic lead_s;
        logic lead_h;
        lead_s = (BLANK_LEADING != 0);
        lead_h = (BLANK_LEADING != 0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_score_disp[k] = r_score[4*(NUM_DIGITS-1-k) +: 4];
            w_high_disp[k]  = r_high[4*(NUM_DIGITS-1-k) +: 4];
            if (lead_s && (k != NUM_DIGITS - 1) && (w_score_disp[k] == 4'd0))
                w_score_disp[k] = 4'hF;
            else
                lead_s = 1'b0;
            if (lead_h && (k != NUM_DIGITS - 1) && (w_high_disp[k] == 4'd0))
                w_high_disp[k] = 4'hF;
            else
                lead_h = 1'b0;
        end
    end

    assign w_in_row = (i_vpos >= 10'(DIGIT_Y)) && (i_vpos < 10'(DIGIT_Y + DIGIT_HEIGHT));
    assign w_ly     = i_vpos - 10'(DIGIT_Y);

    always_comb begin : cell_decode
        w_live_hit   = 1'b0;
        w_live_digit = 4'hF;
        w_live_lx    = '0;
        w_high_hit   = 1'b0;
        w_high_digit = 4'hF;
        w_high_lx    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((i_hpos >= 10'(SCORE_X + k*PITCH)) &&
                (i_hpos <  10'(SCORE_X + k*PITCH + DIGIT_WIDTH))) begin
                w_live_hit   = 1'b1;
                w_live_digit = w_score_disp[k];
                w_live_lx    = i_hpos - 10'(SCORE_X + k*PITCH);
            end
            if ((i_hpos >= 10'(HIGH_X + k*PITCH)) &&
                (i_hpos <  10'(HIGH_X + k*PITCH + DIGIT_WIDTH))) begin
                w_high_hit   = 1'b1;
                w_high_digit = w_high_disp[k];
                w_high_lx    = i_hpos - 10'(HIGH_X + k*PITCH);
            end
        end
    end

    digit_glyph #(.DIGIT_WIDTH(DIGIT_WIDTH), .DIGIT_HEIGHT(DIGIT_HEIGHT)) u_live_glyph (
        .i_x     (w_live_lx),
        .i_y     (w_ly),
        .i_digit (w_live_digit),
        .o_lit   (w_live_lit)
    );

    digit_glyph #(.DIGIT_WIDTH(DIGIT_WIDTH), .DIGIT_HEIGHT(DIGIT_HEIGHT)) u_high_glyph (
        .i_x     (w_high_lx),
        .i_y     (w_ly),
        .i_digit (w_high_digit),
        .o_lit   (w_high_lit)
    );

    always_comb begin
        w_rgb_next = BANNER_COLOR;
        if (i_vpos >= 10'(BANNER_HEIGHT))
            w_rgb_next = 3'b000;
        else if (w_live_hit && w_in_row && w_live_lit)
            w_rgb_next = (r_new_high && r_blink) ? BANNER_COLOR : SCORE_COLOR;
        else if (w_high_hit && w_in_row && w_high_lit)
            w_rgb_next = HIGH_COLOR;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rgb <= 3'b000;
        else          r_rgb <= w_rgb_next;
    end

    assign o_score_bcd = r_score;
    assign o_high_bcd  = r_high;
    assign o_new_high  = r_new_high;
    assign o_score_rgb = r_rgb;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed plus randomized bench for score_bcd_display against an integer-level model.
module tb_score_bcd_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       frame_tick = 1'b0;
  logic       score_inc = 1'b0;
  logic       score_clr = 1'b0;
  logic [11:0] score_bcd, high_bcd;
  logic       new_high;
  logic [2:0] score_rgb;

  int n_checks = 0;
  int n_err = 0;

  // model state: plain integers
  int m_score = 0;
  int m_high = 0;
  bit m_nh = 0;
  int m_frames = 0;

  score_bcd_display dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hpos(hpos), .i_vpos(vpos),
    .i_frame_tick(frame_tick), .i_score_inc(score_inc), .i_score_clr(score_clr),
    .o_score_bcd(score_bcd), .o_high_bcd(high_bcd), .o_new_high(new_high),
    .o_score_rgb(score_rgb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int n);
    logic [31:0] r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < 3; i++) begin
      r = r | (32'((n / p) % 10) << (4 * i));
      p = p * 10;
    end
    return r;
  endfunction

  function automatic bit seg_lit(input int d, input int x, input int y);
    string segs;
    bit lit;
    case (d)
      0: segs = "abcdef";
      1: segs = "bc";
      2: segs = "abdeg";
      3: segs = "abcdg";
      4: segs = "bcfg";
      5: segs = "acdfg";
      6: segs = "acdefg";
      7: segs = "abc";
      8: segs = "abcdefg";
      default: segs = "abcdfg";
    endcase
    lit = 0;
    for (int i = 0; i < segs.len(); i++) begin
      case (segs[i])
        "a": if (y <= 3) lit = 1;
        "b": if (x >= 8 && y <= 15) lit = 1;
        "c": if (x >= 8 && y >= 12) lit = 1;
        "d": if (y >= 24) lit = 1;
        "e": if (x <= 3 && y >= 12) lit = 1;
        "f": if (x <= 3 && y <= 15) lit = 1;
        "g": if (y >= 12 && y <= 15) lit = 1;
        default: ;
      endcase
    end
    return lit;
  endfunction

  // Three 12x28 cells on a 16 px pitch starting at x0, top at y=2.
  function automatic bit cell_lit(input int val, input int x0, input int h, input int v);
    int cx, p;
    for (int k = 0; k < 3; k++) begin
      cx = x0 + 16 * k;
      p = (k == 0) ? 100 : ((k == 1) ? 10 : 1);
      if (h >= cx && h < cx + 12 && v >= 2 && v < 30) begin
        if (k < 2 && val < p) return 0;
        return seg_lit((val / p) % 10, h - cx, v - 2);
      end
    end
    return 0;
  endfunction

  function automatic logic [2:0] exp_pix(input int h, input int v);
    if (v >= 32) return 3'b000;
    if (cell_lit(m_score, 590, h, v))
      return (m_nh && ((m_frames / 16) % 2 == 1)) ? 3'b000 : 3'b100;
    if (cell_lit(m_high, 8, h, v)) return 3'b110;
    return 3'b000;
  endfunction

  // One clock: drive inputs, advance, check every output against the model.
  task automatic step(input bit inc, input bit clr, input bit tick, input int h, input int v);
    logic [2:0] ep;
    ep = exp_pix(h, v);
    score_inc = inc;
    score_clr = clr;
    frame_tick = tick;
    hpos = 10'(h);
    vpos = 10'(v);
    @(posedge clk);
    #1;
    score_inc = 0;
    score_clr = 0;
    frame_tick = 0;
    if (clr) begin
      if (m_score > m_high) m_high = m_score;
      m_score = 0;
      m_nh = 0;
    end else begin
      if (inc && m_score < 999) m_score++;
      m_nh = (m_score > m_high);
    end
    if (tick) m_frames++;
    chk("rgb", 32'(score_rgb), 32'(ep));
    chk("score_bcd", 32'(score_bcd), to_bcd(m_score));
    chk("high_bcd", 32'(high_bcd), to_bcd(m_high));
    chk("new_high", 32'(new_high), 32'(m_nh));
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 40);
  endtask

  initial begin
    int r, h, v;
    // power-on reset
    #12;
    chk("rst_rgb", 32'(score_rgb), 0);
    chk("rst_score", 32'(score_bcd), 0);
    chk("rst_high", 32'(high_bcd), 0);
    chk("rst_nh", 32'(new_high), 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // score 0 renders "0" in the ones cell only
    step(0, 0, 0, 622 + 1, 22);
    chk("zero_ones_e", 32'(score_rgb), 32'(3'b100));
    step(0, 0, 0, 590 + 1, 22);
    chk("zero_hund_blank", 32'(score_rgb), 0);

    // simultaneous clear and increment at score 5
    incs(5);
    step(1, 1, 0, 0, 40);
    chk("simul_score", 32'(score_bcd), 0);
    chk("simul_high", 32'(high_bcd), 32'h005);
    chk("simul_nh", 32'(new_high), 0);

    // asynchronous reset mid-line with a lit pixel in flight
    step(0, 0, 0, 40 + 9, 22);
    #2;
    rst_n = 0;
    #1;
    chk("async_rgb", 32'(score_rgb), 0);
    chk("async_score", 32'(score_bcd), 0);
    chk("async_high", 32'(high_bcd), 0);
    chk("async_nh", 32'(new_high), 0);
    m_score = 0; m_high = 0; m_nh = 0; m_frames = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    step(0, 0, 0, 622 + 9, 22);
    chk("after_rst_zero", 32'(score_rgb), 32'(3'b100));

    // render score 7
    incs(7);
    step(0, 0, 0, 590 + 5, 3);
    chk("r7_hund_bg", 32'(score_rgb), 0);
    step(0, 0, 0, 606 + 5, 3);
    chk("r7_tens_bg", 32'(score_rgb), 0);
    step(0, 0, 0, 622 + 9, 22);
    chk("r7_ones_c", 32'(score_rgb), 32'(3'b100));
    step(0, 0, 0, 622 + 1, 22);
    chk("r7_ones_e_off", 32'(score_rgb), 0);
    step(0, 0, 0, 622 + 9, 32);
    chk("r7_below_banner", 32'(score_rgb), 0);

    // high-score update sequence
    incs(35);
    step(0, 1, 0, 0, 40);
    chk("hs_42", 32'(high_bcd), 32'h042);
    incs(17);
    step(0, 1, 0, 0, 40);
    chk("hs_keep_42", 32'(high_bcd), 32'h042);
    incs(42);
    chk("hs_nh_at_42", 32'(new_high), 0);
    incs(1);
    chk("hs_nh_at_43", 32'(new_high), 1);

    // blink: ones digit 3 segment a at (627,3); high ones digit 2 at (45,3)
    for (int i = 0; i < 16; i++) step(0, 0, 1, 627, 3);
    step(0, 0, 0, 627, 3);
    chk("blink_off", 32'(score_rgb), 32'(3'b000));
    step(0, 0, 0, 45, 3);
    chk("blink_high", 32'(score_rgb), 32'(3'b110));
    for (int i = 0; i < 16; i++) step(0, 0, 1, 45, 3);
    step(0, 0, 0, 627, 3);
    chk("blink_on", 32'(score_rgb), 32'(3'b100));

    // carry chain and saturation
    step(0, 1, 0, 0, 40);
    incs(9);
    chk("carry_009", 32'(score_bcd), 32'h009);
    incs(1);
    chk("carry_010", 32'(score_bcd), 32'h010);
    incs(989);
    chk("carry_999", 32'(score_bcd), 32'h999);
    incs(1);
    chk("sat_999", 32'(score_bcd), 32'h999);
    step(0, 1, 0, 0, 40);
    chk("sat_high", 32'(high_bcd), 32'h999);
    step(0, 0, 0, 8 + 5, 3);
    chk("high_9_a", 32'(score_rgb), 32'(3'b110));

    // randomized traffic with pixel sampling around both value fields
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 3);
      if (r < 2)       h = 590 + $urandom_range(0, 47);
      else if (r == 2) h = 8 + $urandom_range(0, 47);
      else             h = $urandom_range(0, 639);
      v = $urandom_range(0, 40);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2,
           $urandom_range(0, 9) < 3, h, v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
